// File: rtl/frame_scheduler_if.sv
// ---------------------------------------------------------------------------
// frame_scheduler_if
// Bundles the byte-receive strobe, the two-bank frame-memory port and the
// LED-driver handshake used by frame_scheduler.
//   master : scheduler side (drives memory writes/reads, LED stream, status)
//   slave  : environment side (SPI receiver, frame memory, LED driver)
// AW is the byte-pointer width; memory addresses are {bank, pointer}.
// ---------------------------------------------------------------------------
interface frame_scheduler_if #(
    parameter int AW = 8
);
    logic          rx_valid;
    logic [7:0]    rx_data;
    logic          mem_wr_en;
    logic [AW:0]   mem_wr_addr;
    logic [7:0]    mem_wr_data;
    logic [AW:0]   mem_rd_addr;
    logic [7:0]    mem_rd_data;
    logic          led_valid;
    logic [7:0]    led_data;
    logic          led_ready;
    logic          frame_done;
    logic          overrun;
    logic          front_bank;

    modport master (
        input  rx_valid, rx_data, mem_rd_data, led_ready,
        output mem_wr_en, mem_wr_addr, mem_wr_data, mem_rd_addr,
               led_valid, led_data, frame_done, overrun, front_bank
    );

    modport slave (
        output rx_valid, rx_data, mem_rd_data, led_ready,
        input  mem_wr_en, mem_wr_addr, mem_wr_data, mem_rd_addr,
               led_valid, led_data, frame_done, overrun, front_bank
    );
endinterface

// File: rtl/frame_scheduler.sv
// ---------------------------------------------------------------------------
// frame_scheduler
// Ping-pong frame buffer controller between an SPI byte receiver and a serial
// LED driver. Incoming bytes fill the back bank; a completed frame is swapped
// to the front at the next idle point and streamed byte-by-byte to the LED
// driver, followed by the strip latch gap.
// Ports:
//   clk    : system clock
//   reset  : asynchronous, active-high reset
//   bus    : frame_scheduler_if.master
//            rx_valid/rx_data       incoming byte strobe
//            mem_wr_*               registered frame-memory write port
//            mem_rd_addr/data       frame-memory read port (1-cycle latency)
//            led_valid/data/ready   LED driver handshake
//            frame_done             pulse at end of latch gap
//            overrun                pulse per dropped byte
//            front_bank             bank displayed / last displayed
// ---------------------------------------------------------------------------
module frame_scheduler #(
    parameter int IMG_WIDTH    = 8,
    parameter int IMG_HEIGHT   = 8,
    parameter int FRAME_BYTES  = 3 * IMG_WIDTH * IMG_HEIGHT,
    parameter int AW           = $clog2(FRAME_BYTES),
    parameter int LATCH_CYCLES = 3000,
    parameter int RX_TIMEOUT   = 50000
) (
    input  logic               clk,
    input  logic               reset,
    frame_scheduler_if.master  bus
);

    localparam int IW = $clog2(RX_TIMEOUT + 1);
    localparam int LW = $clog2(LATCH_CYCLES + 1);

    localparam logic [AW-1:0] LAST_PTR   = AW'(FRAME_BYTES - 1);
    localparam logic [IW-1:0] IDLE_MAX   = IW'(RX_TIMEOUT);
    localparam logic [LW-1:0] LATCH_LAST = LW'(LATCH_CYCLES - 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_SEND  = 3'd3;
    localparam logic [2:0] ST_LATCH = 3'd4;

    logic [2:0]    state_q,       state_d;
    logic          wr_bank_q,     wr_bank_d;
    logic [AW-1:0] wr_ptr_q,      wr_ptr_d;
    logic          pending_q,     pending_d;
    logic [IW-1:0] idle_cnt_q,    idle_cnt_d;
    logic          rd_bank_q,     rd_bank_d;
    logic [AW-1:0] rd_ptr_q,      rd_ptr_d;
    logic [LW-1:0] latch_cnt_q,   latch_cnt_d;
    logic          mem_wr_en_q,   mem_wr_en_d;
    logic [AW:0]   mem_wr_addr_q, mem_wr_addr_d;
    logic [7:0]    mem_wr_data_q, mem_wr_data_d;
    logic [AW:0]   mem_rd_addr_q, mem_rd_addr_d;
    logic          led_valid_q,   led_valid_d;
    logic [7:0]    led_data_q,    led_data_d;
    logic          frame_done_q,  frame_done_d;
    logic          overrun_q,     overrun_d;
    logic          front_bank_q,  front_bank_d;

    // Next-state logic for the byte-capture side and the read/stream FSM
    always_comb begin
        state_d       = state_q;
        wr_bank_d     = wr_bank_q;
        wr_ptr_d      = wr_ptr_q;
        pending_d     = pending_q;
        idle_cnt_d    = idle_cnt_q;
        rd_bank_d     = rd_bank_q;
        rd_ptr_d      = rd_ptr_q;
        latch_cnt_d   = latch_cnt_q;
        mem_wr_en_d   = 1'b0;
        mem_wr_addr_d = mem_wr_addr_q;
        mem_wr_data_d = mem_wr_data_q;
        mem_rd_addr_d = mem_rd_addr_q;
        led_valid_d   = led_valid_q;
        led_data_d    = led_data_q;
        frame_done_d  = 1'b0;
        overrun_d     = 1'b0;
        front_bank_d  = front_bank_q;

        // Write side: bytes land in the back bank unless a finished frame
        // is still waiting for the display side to pick it up.
        if (bus.rx_valid) begin
            idle_cnt_d = {IW{1'b0}};
            if (!pending_q) begin
                mem_wr_en_d   = 1'b1;
                mem_wr_addr_d = {wr_bank_q, wr_ptr_q};
                mem_wr_data_d = bus.rx_data;
                if (wr_ptr_q == LAST_PTR) begin
                    wr_ptr_d  = {AW{1'b0}};
                    pending_d = 1'b1;
                end else begin
                    wr_ptr_d  = wr_ptr_q + 1'b1;
                end
            end else begin
                overrun_d = 1'b1;
            end
        end else begin
            if (idle_cnt_q != IDLE_MAX) begin
                idle_cnt_d = idle_cnt_q + 1'b1;
            end else begin
                idle_cnt_d = idle_cnt_q;
            end
            // A stalled sender leaves a partial frame; restart from byte 0.
            if ((idle_cnt_q == IDLE_MAX) && (wr_ptr_q != {AW{1'b0}})) begin
                wr_ptr_d = {AW{1'b0}};
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
        end

        // Read side. pending is only set by the write side when it was clear
        // and only cleared here when it was set, so the two never collide.
        case (state_q)
            ST_IDLE: begin
                if (pending_q) begin
                    rd_bank_d    = wr_bank_q;
                    wr_bank_d    = ~wr_bank_q;
                    front_bank_d = wr_bank_q;
                    pending_d    = 1'b0;
                    rd_ptr_d     = {AW{1'b0}};
                    state_d      = ST_FETCH;
                end else begin
                    state_d      = ST_IDLE;
                end
            end
            ST_FETCH: begin
                mem_rd_addr_d = {rd_bank_q, rd_ptr_q};
                state_d       = ST_WAIT;
            end
            ST_WAIT: begin
                state_d = ST_SEND;
            end
            ST_SEND: begin
                // First SEND cycle: read data is valid now, capture it and
                // raise valid; afterwards hold both until the handshake.
                if (!led_valid_q) begin
                    led_data_d  = bus.mem_rd_data;
                    led_valid_d = 1'b1;
                end else if (bus.led_ready) begin
                    led_valid_d = 1'b0;
                    if (rd_ptr_q == LAST_PTR) begin
                        latch_cnt_d = {LW{1'b0}};
                        state_d     = ST_LATCH;
                    end else begin
                        rd_ptr_d    = rd_ptr_q + 1'b1;
                        state_d     = ST_FETCH;
                    end
                end else begin
                    led_valid_d = led_valid_q;
                end
            end
            ST_LATCH: begin
                if (latch_cnt_q == LATCH_LAST) begin
                    frame_done_d = 1'b1;
                    state_d      = ST_IDLE;
                end else begin
                    latch_cnt_d  = latch_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                led_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            wr_bank_q     <= 1'b1;
            wr_ptr_q      <= {AW{1'b0}};
            pending_q     <= 1'b0;
            idle_cnt_q    <= {IW{1'b0}};
            rd_bank_q     <= 1'b0;
            rd_ptr_q      <= {AW{1'b0}};
            latch_cnt_q   <= {LW{1'b0}};
            mem_wr_en_q   <= 1'b0;
            mem_wr_addr_q <= {(AW+1){1'b0}};
            mem_wr_data_q <= 8'h00;
            mem_rd_addr_q <= {(AW+1){1'b0}};
            led_valid_q   <= 1'b0;
            led_data_q    <= 8'h00;
            frame_done_q  <= 1'b0;
            overrun_q     <= 1'b0;
            front_bank_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_bank_q     <= wr_bank_d;
            wr_ptr_q      <= wr_ptr_d;
            pending_q     <= pending_d;
            idle_cnt_q    <= idle_cnt_d;
            rd_bank_q     <= rd_bank_d;
            rd_ptr_q      <= rd_ptr_d;
            latch_cnt_q   <= latch_cnt_d;
            mem_wr_en_q   <= mem_wr_en_d;
            mem_wr_addr_q <= mem_wr_addr_d;
            mem_wr_data_q <= mem_wr_data_d;
            mem_rd_addr_q <= mem_rd_addr_d;
            led_valid_q   <= led_valid_d;
            led_data_q    <= led_data_d;
            frame_done_q  <= frame_done_d;
            overrun_q     <= overrun_d;
            front_bank_q  <= front_bank_d;
        end
    end

    assign bus.mem_wr_en   = mem_wr_en_q;
    assign bus.mem_wr_addr = mem_wr_addr_q;
    assign bus.mem_wr_data = mem_wr_data_q;
    assign bus.mem_rd_addr = mem_rd_addr_q;
    assign bus.led_valid   = led_valid_q;
    assign bus.led_data    = led_data_q;
    assign bus.frame_done  = frame_done_q;
    assign bus.overrun     = overrun_q;
    assign bus.front_bank  = front_bank_q;

endmodule

// File: tb/tb_frame_scheduler.sv
// ---------------------------------------------------------------------------
// tb_frame_scheduler
// Directed bench for frame_scheduler with a 2x2 image (12 bytes per frame),
// a 20-cycle latch gap and a 50-cycle receive timeout. Includes a behavioural
// two-bank frame memory and a negedge monitor that logs writes, LED
// handshakes, overrun and frame_done pulses.
// ---------------------------------------------------------------------------
module tb_frame_scheduler;

    localparam int AW = 4;

    typedef struct {
        logic [7:0] rx;
        logic [4:0] exp_addr;
        logic [7:0] exp_led;
        logic       exp_front;
    } vec_t;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    frame_scheduler_if #(.AW(AW)) bus ();

    frame_scheduler #(
        .IMG_WIDTH   (2),
        .IMG_HEIGHT  (2),
        .LATCH_CYCLES(20),
        .RX_TIMEOUT  (50)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // Behavioural frame memory: registered write, 1-cycle synchronous read
    logic [7:0] mem [0:31];
    always @(posedge clk) begin
        if (bus.mem_wr_en) mem[bus.mem_wr_addr] <= bus.mem_wr_data;
        bus.mem_rd_data <= mem[bus.mem_rd_addr];
    end

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int ovr_cnt  = 0;
    int fd_cnt   = 0;
    int hs_cyc   = 0;
    int fd_cyc   = 0;
    int stab_err = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'h00;
    logic [12:0] wr_q [$];
    logic [7:0]  led_q [$];
    vec_t tbl [24];

    // Posedge counter used to time latencies
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: log DUT activity away from the active edge
    always @(negedge clk) begin
        if (reset) begin
            prev_stall <= 1'b0;
        end else begin
            if (bus.mem_wr_en) wr_q.push_back({bus.mem_wr_addr, bus.mem_wr_data});
            if (bus.led_valid && bus.led_ready) begin
                led_q.push_back(bus.led_data);
                hs_cyc <= cyc;
            end
            if (bus.overrun) ovr_cnt <= ovr_cnt + 1;
            if (bus.frame_done) begin
                fd_cnt <= fd_cnt + 1;
                fd_cyc <= cyc;
            end
            if (prev_stall && (!bus.led_valid || bus.led_data != prev_data))
                stab_err <= stab_err + 1;
            prev_stall <= bus.led_valid && !bus.led_ready;
            prev_data  <= bus.led_data;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        tick();
        bus.rx_valid = 1'b0;
        repeat (gap - 1) tick();
    endtask

    task automatic wait_fd(input int target);
        int k;
        k = 0;
        while (fd_cnt < target && k < 2000) begin
            tick();
            k++;
        end
        check("frame_done_count", fd_cnt, target);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mem_wr_en"},   int'(bus.mem_wr_en),   0);
        check({tag, "_mem_wr_addr"}, int'(bus.mem_wr_addr), 0);
        check({tag, "_mem_wr_data"}, int'(bus.mem_wr_data), 0);
        check({tag, "_mem_rd_addr"}, int'(bus.mem_rd_addr), 0);
        check({tag, "_led_valid"},   int'(bus.led_valid),   0);
        check({tag, "_led_data"},    int'(bus.led_data),    0);
        check({tag, "_frame_done"},  int'(bus.frame_done),  0);
        check({tag, "_overrun"},     int'(bus.overrun),     0);
        check({tag, "_front_bank"},  int'(bus.front_bank),  0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Frame 1: bank 1, bytes 0x01..0x0C; frame 2: bank 0, bytes 0x21..0x2C
        for (int i = 0; i < 12; i++) begin
            tbl[i]      = '{8'(8'h01 + i), 5'(5'h10 + i), 8'(8'h01 + i), 1'b1};
            tbl[12 + i] = '{8'(8'h21 + i), 5'(5'h00 + i), 8'(8'h21 + i), 1'b0};
        end

        reset         = 1'b1;
        bus.rx_valid  = 1'b0;
        bus.rx_data   = 8'h00;
        bus.led_ready = 1'b1;
        repeat (3) tick();
        check_all_zero("reset");
        reset = 1'b0;
        tick();

        // Two back-to-back full frames from the vector table
        for (int f = 0; f < 2; f++) begin
            wr_q.delete();
            led_q.delete();
            for (int i = 0; i < 12; i++) send_byte(tbl[f*12 + i].rx, 16);
            wait_fd(f + 1);
            check("wr_count", wr_q.size(), 12);
            check("led_count", led_q.size(), 12);
            for (int i = 0; i < 12; i++) begin
                if (i < wr_q.size())
                    check("wr_addr_data", int'(wr_q[i]), int'({tbl[f*12+i].exp_addr, tbl[f*12+i].rx}));
                if (i < led_q.size())
                    check("led_data", int'(led_q[i]), int'(tbl[f*12+i].exp_led));
            end
            check("front_bank", int'(bus.front_bank), int'(tbl[f*12].exp_front));
            // 20 posedges from the last handshake edge to the frame_done edge
            check("latch_gap", fd_cyc - hs_cyc, 21);
        end
        check("overrun_none", ovr_cnt, 0);

        // Partial frame abandoned by the idle timeout
        wr_q.delete();
        led_q.delete();
        for (int i = 0; i < 5; i++) send_byte(8'(8'h31 + i), 16);
        repeat (60) tick();
        for (int i = 0; i < 12; i++) send_byte(8'(8'h41 + i), 16);
        wait_fd(3);
        check("timeout_wr_count", wr_q.size(), 17);
        if (wr_q.size() > 5) check("timeout_restart_addr", int'(wr_q[5]), int'({5'h10, 8'h41}));
        check("timeout_led_count", led_q.size(), 12);
        for (int i = 0; i < 12; i++)
            if (i < led_q.size()) check("timeout_led_data", int'(led_q[i]), 8'h41 + i);
        check("timeout_overrun", ovr_cnt, 0);
        check("timeout_front", int'(bus.front_bank), 1);

        // LED driver stalls on the first byte while the next frame fills up
        bus.led_ready = 1'b0;
        wr_q.delete();
        led_q.delete();
        for (int i = 0; i < 12; i++) send_byte(8'(8'h51 + i), 16);
        begin
            int k;
            k = 0;
            while (!bus.led_valid && k < 100) begin
                tick();
                k++;
            end
        end
        check("stall_valid_up", int'(bus.led_valid), 1);
        begin
            int t0;
            t0 = cyc;
            for (int i = 0; i < 12; i++) send_byte(8'(8'h61 + i), 5);
            for (int i = 0; i < 3; i++) send_byte(8'(8'h71 + i), 5);
            while (cyc - t0 < 100) tick();
        end
        check("stall_led_data", int'(bus.led_data), 8'h51);
        check("stall_led_valid", int'(bus.led_valid), 1);
        check("stall_stability", stab_err, 0);
        check("stall_no_handshake", led_q.size(), 0);
        check("stall_overrun", ovr_cnt, 3);
        check("stall_front", int'(bus.front_bank), 0);
        check("stall_wr_count", wr_q.size(), 24);
        for (int i = 0; i < 12; i++)
            if (12 + i < wr_q.size())
                check("stall_wr_addr_data", int'(wr_q[12+i]), int'({5'(5'h10 + i), 8'(8'h61 + i)}));
        bus.led_ready = 1'b1;
        wait_fd(5);
        check("stall_led_count", led_q.size(), 24);
        for (int i = 0; i < 12; i++) begin
            if (i < led_q.size())      check("stall_led_a", int'(led_q[i]), 8'h51 + i);
            if (12 + i < led_q.size()) check("stall_led_b", int'(led_q[12+i]), 8'h61 + i);
        end
        check("stall_front_end", int'(bus.front_bank), 1);
        check("stall_overrun_end", ovr_cnt, 3);

        // Reset while byte 6 of a frame is being presented
        wr_q.delete();
        led_q.delete();
        for (int i = 0; i < 12; i++) send_byte(8'(8'h81 + i), 16);
        begin
            int k;
            k = 0;
            while (!(bus.led_valid && led_q.size() == 6) && k < 500) begin
                tick();
                k++;
            end
        end
        check("byte6_valid", int'(bus.led_valid), 1);
        check("byte6_data", int'(bus.led_data), 8'h87);
        reset = 1'b1;
        #1;
        check_all_zero("midreset");
        tick();
        tick();
        reset = 1'b0;
        wr_q.delete();
        led_q.delete();
        ovr_cnt = 0;
        tick();
        for (int i = 0; i < 12; i++) send_byte(8'(8'h91 + i), 16);
        wait_fd(6);
        check("postreset_wr_count", wr_q.size(), 12);
        check("postreset_led_count", led_q.size(), 12);
        for (int i = 0; i < 12; i++) begin
            if (i < wr_q.size())
                check("postreset_wr", int'(wr_q[i]), int'({5'(5'h10 + i), 8'(8'h91 + i)}));
            if (i < led_q.size())
                check("postreset_led", int'(led_q[i]), 8'h91 + i);
        end
        check("postreset_front", int'(bus.front_bank), 1);
        check("postreset_overrun", ovr_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
